lap_recorder: RTL and testbench
===============================

Name: lap_recorder

Overview:
- Sits between stopwatch_core and display_controller.
- Takes the live 6-digit BCD time and captures lap times into a small on-chip memory on lap requests.
- Drives the 24-bit BCD word and decimal-point control consumed by display_controller: live time, a frozen just-captured lap, or a browsed stored lap.
- Button inputs arrive as clean single-cycle pulses; debouncing is done upstream.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- DEPTH, 8, number of lap entries stored (≥1).
- HOLD_TIME_MS, 2000, duration the captured lap is frozen on the display.
- BLINK_MS, 250, decimal-point toggle half-period while browsing laps.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- bcd_time_in  input  24  live BCD time from stopwatch_core.
- lap_pulse_in  input  1  single-cycle lap capture request.
- recall_pulse_in  input  1  single-cycle request to enter/step lap browsing.
- clear_pulse_in  input  1  single-cycle request to erase all stored laps.
- bcd_data_out  output  24  BCD word to display_controller.
- dp_out  output  1  decimal-point control to display_controller.
- lap_count_out  output  $clog2(DEPTH+1)  number of stored laps.
- full_out  output  1  high when lap_count_out == DEPTH.
- overflow_out  output  1  one-cycle pulse when a lap is rejected because memory is full.
- showing_lap_out  output  1  high in FREEZE or RECALL.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=LIVE; bcd_data_out=0; dp_out=0; lap_count_out=0; full_out=0; overflow_out=0; showing_lap_out=0; rd_idx=0; timers=0. Reset mid-operation aborts everything; memory contents are don't-care, but count=0 makes them unreachable.
- Derived constants:
  - HOLD_CYCLES = CLK_FREQ_HZ/1000*HOLD_TIME_MS.
  - BLINK_CYCLES = CLK_FREQ_HZ/1000*BLINK_MS.
  - Both are computed at elaboration and must be ≥1.
- All outputs are registered. bcd_data_out reflects the source selected in cycle N at cycle N+1.
- LIVE:
  - bcd_data_out <= bcd_time_in; dp_out=0.
  - lap with count<DEPTH: mem[count] <= bcd_time_in; count++; frz_val <= bcd_time_in; hold timer cleared; go FREEZE.
  - lap with count==DEPTH: no write; overflow_out pulses 1 cycle; stay LIVE.
  - recall with count>0: rd_idx=0 (oldest); blink timer cleared; dp_out=1; go RECALL.
  - recall with count==0: ignored.
- FREEZE:
  - bcd_data_out <= frz_val; dp_out=0.
  - Hold timer counts; at HOLD_CYCLES-1 go LIVE.
  - lap: same capture/overflow rules as LIVE. A successful capture restarts the hold timer with the new value. Overflow keeps the current freeze and its timer running.
  - recall: enter RECALL as from LIVE (count>0 is guaranteed).
- RECALL:
  - bcd_data_out <= mem[rd_idx].
  - dp_out toggles every BLINK_CYCLES, starting at 1 on entry.
  - recall: if rd_idx < count-1, rd_idx++ and blink restarts at dp=1; else go LIVE with rd_idx=0.
  - lap: ignored in RECALL (no capture, no overflow).
  - No timeout.
- Clear (any state): count=0; rd_idx=0; state=LIVE; all timers cleared.
- Simultaneous pulses, priority order:
  - Clear has highest priority; other pulses in the same cycle are ignored.
  - lap beats recall in LIVE/FREEZE; recall is dropped.
- full_out = (count==DEPTH), registered alongside count. showing_lap_out = state≠LIVE.
- bcd_time_in is captured verbatim; no BCD validation. Lap capture does not affect stopwatch_core.

Test Plan:
1. Reset, bcd_time_in=24'h001234 → bcd_data_out=0 during reset, 24'h001234 one cycle after release; lap_count_out=0, dp_out=0.
2. CLK_FREQ_HZ=1000, HOLD_TIME_MS=5, bcd_time_in=24'h000512, pulse lap, then input advances → output holds 24'h000512 for exactly 5 cycles, showing_lap_out=1, then tracks live; lap_count_out=1.
3. DEPTH=2, three laps at 24'h000100/24'h000200/24'h000300 → count=2, full_out=1, overflow_out pulses once on the third; memory holds 24'h000100/24'h000200.
4. Two laps stored, BLINK_MS=2, recall ×3 → shows 24'h000100 then 24'h000200 with dp toggling every 2 cycles, third recall returns to live with dp_out=0.
5. lap, recall and clear pulsed in the same cycle while in FREEZE with count=1 → count=0, state LIVE, no capture; next recall ignored.
6. rst_n asserted mid-RECALL, asynchronous to clk → outputs zero immediately, count=0; after release, recall is ignored.

Source files
------------

// File: rtl/lap_recorder.sv
// ============================================================================
// lap_recorder: captures lap times from the live BCD stopwatch value and
// selects live / frozen / browsed-lap data for the display. Rev 1.0
// ============================================================================
`default_nettype none

module lap_recorder #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int DEPTH        = 8,
  parameter int HOLD_TIME_MS = 2000,
  parameter int BLINK_MS     = 250,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      bcd_time_in,
  input  logic             lap_pulse_in,
  input  logic             recall_pulse_in,
  input  logic             clear_pulse_in,
  output logic [23:0]      bcd_data_out,
  output logic             dp_out,
  output logic [CNT_W-1:0] lap_count_out,
  output logic             full_out,
  output logic             overflow_out,
  output logic             showing_lap_out
);

  localparam int HOLD_CYCLES  = CLK_FREQ_HZ / 1000 * HOLD_TIME_MS;
  localparam int BLINK_CYCLES = CLK_FREQ_HZ / 1000 * BLINK_MS;
  localparam int HOLD_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BLINK_W      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEPTH);

  localparam logic [1:0] ST_LIVE   = 2'd0;
  localparam logic [1:0] ST_FREEZE = 2'd1;
  localparam logic [1:0] ST_RECALL = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [23:0]        frz_val_q, frz_val_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [23:0]        data_q, data_d;
  logic               dp_q, dp_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;
  logic               showing_q, showing_d;

  logic               wr_en;
  logic               blink_restart;
  logic               blink_flip;
  logic [IDX_W-1:0]   wr_idx;
  logic               has_next;

  // Lap memory has no reset: a zero count makes stale entries unreachable.
  logic [23:0]        mem_q [DEPTH];

  assign wr_idx   = IDX_W'(count_q);
  assign has_next = (CNT_W'(rd_idx_q) + CNT_W'(1)) < count_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LIVE;
      count_q     <= '0;
      rd_idx_q    <= '0;
      frz_val_q   <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      data_q      <= '0;
      dp_q        <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      showing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      frz_val_q   <= frz_val_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      data_q      <= data_d;
      dp_q        <= dp_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      showing_q   <= showing_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= bcd_time_in;
    end
  end

  // Next-state and timer logic; clear overrides every other pulse.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rd_idx_d      = rd_idx_q;
    frz_val_d     = frz_val_q;
    hold_cnt_d    = hold_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    overflow_d    = 1'b0;
    wr_en         = 1'b0;
    blink_restart = 1'b0;
    blink_flip    = 1'b0;

    if (clear_pulse_in) begin
      state_d     = ST_LIVE;
      count_d     = '0;
      rd_idx_d    = '0;
      hold_cnt_d  = '0;
      blink_cnt_d = '0;
    end else begin
      case (state_q)
        ST_LIVE, ST_FREEZE: begin
          if (state_q == ST_FREEZE) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_d    = ST_LIVE;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
          if (lap_pulse_in) begin
            if (!full_q) begin
              wr_en      = 1'b1;
              count_d    = count_q + CNT_W'(1);
              frz_val_d  = bcd_time_in;
              hold_cnt_d = '0;
              state_d    = ST_FREEZE;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (recall_pulse_in && (count_q != '0)) begin
            state_d       = ST_RECALL;
            rd_idx_d      = '0;
            hold_cnt_d    = '0;
            blink_cnt_d   = '0;
            blink_restart = 1'b1;
          end
        end
        ST_RECALL: begin
          if (recall_pulse_in) begin
            blink_cnt_d = '0;
            if (has_next) begin
              rd_idx_d      = rd_idx_q + IDX_W'(1);
              blink_restart = 1'b1;
            end else begin
              state_d  = ST_LIVE;
              rd_idx_d = '0;
            end
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_flip  = 1'b1;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
        end
        default: begin
          state_d = ST_LIVE;
        end
      endcase
    end
  end

  // Registered outputs follow the state being entered, so a capture is
  // visible on the display for exactly the hold window.
  always_comb begin
    data_d    = bcd_time_in;
    dp_d      = 1'b0;
    full_d    = (count_d == CNT_FULL);
    showing_d = (state_d != ST_LIVE);
    case (state_d)
      ST_FREEZE: begin
        data_d = frz_val_d;
      end
      ST_RECALL: begin
        data_d = mem_q[rd_idx_d];
        if (blink_restart) begin
          dp_d = 1'b1;
        end else begin
          dp_d = blink_flip ? ~dp_q : dp_q;
        end
      end
      default: begin
        data_d = bcd_time_in;
      end
    endcase
  end

  assign bcd_data_out    = data_q;
  assign dp_out          = dp_q;
  assign lap_count_out   = count_q;
  assign full_out        = full_q;
  assign overflow_out    = overflow_q;
  assign showing_lap_out = showing_q;

endmodule

`default_nettype wire

// File: tb/tb_lap_recorder.sv
// ============================================================================
// tb_lap_recorder: directed vector table plus hand-written reset/recall
// sequences for lap_recorder. Rev 1.0
// ============================================================================
`default_nettype none

module tb_lap_recorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] bcd_time_in;
  logic        lap_pulse_in, recall_pulse_in, clear_pulse_in;
  logic [23:0] bcd_data_out;
  logic        dp_out;
  logic [1:0]  lap_count_out;
  logic        full_out, overflow_out, showing_lap_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lap_recorder #(
    .CLK_FREQ_HZ (1000),
    .DEPTH       (2),
    .HOLD_TIME_MS(5),
    .BLINK_MS    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bcd_time_in    (bcd_time_in),
    .lap_pulse_in   (lap_pulse_in),
    .recall_pulse_in(recall_pulse_in),
    .clear_pulse_in (clear_pulse_in),
    .bcd_data_out   (bcd_data_out),
    .dp_out         (dp_out),
    .lap_count_out  (lap_count_out),
    .full_out       (full_out),
    .overflow_out   (overflow_out),
    .showing_lap_out(showing_lap_out)
  );

  typedef struct {
    logic [23:0] bcd;
    logic        lap, rec, clr;
    logic [23:0] e_data;
    logic        e_dp;
    logic [1:0]  e_cnt;
    logic        e_full, e_ovf, e_show;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [23:0] bcd, input logic lap, input logic rec,
                     input logic clr, input logic [23:0] e_data, input logic e_dp,
                     input logic [1:0] e_cnt, input logic e_full, input logic e_ovf,
                     input logic e_show);
    vec_t v;
    v.bcd = bcd; v.lap = lap; v.rec = rec; v.clr = clr;
    v.e_data = e_data; v.e_dp = e_dp; v.e_cnt = e_cnt;
    v.e_full = e_full; v.e_ovf = e_ovf; v.e_show = e_show;
    vecs.push_back(v);
  endtask

  // Packed view: {data, dp, count, full, overflow, showing}
  function automatic logic [29:0] outs();
    return {bcd_data_out, dp_out, lap_count_out, full_out, overflow_out, showing_lap_out};
  endfunction

  task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (data,dp,cnt,full,ovf,show)", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bcd_time_in = 24'h001234;
    lap_pulse_in = 1'b0; recall_pulse_in = 1'b0; clear_pulse_in = 1'b0;

    //   bcd        lap rec clr  data       dp cnt full ovf show
    add(24'h001234, 0, 0, 0, 24'h001234, 0, 0, 0, 0, 0);
    add(24'h000512, 1, 0, 0, 24'h000512, 0, 1, 0, 0, 1);
    add(24'h000513, 0, 0, 0, 24'h000512, 0, 1, 0, 0, 1);
    add(24'h000514, 0, 0, 0, 24'h000512, 0, 1, 0, 0, 1);
    add(24'h000515, 0, 0, 0, 24'h000512, 0, 1, 0, 0, 1);
    add(24'h000516, 0, 0, 0, 24'h000512, 0, 1, 0, 0, 1);
    add(24'h000517, 0, 0, 0, 24'h000517, 0, 1, 0, 0, 0);
    add(24'h000518, 0, 0, 0, 24'h000518, 0, 1, 0, 0, 0);
    add(24'h000600, 0, 0, 1, 24'h000600, 0, 0, 0, 0, 0);
    add(24'h000700, 0, 1, 0, 24'h000700, 0, 0, 0, 0, 0);
    add(24'h000100, 1, 0, 0, 24'h000100, 0, 1, 0, 0, 1);
    add(24'h000150, 1, 1, 1, 24'h000150, 0, 0, 0, 0, 0);
    add(24'h000160, 0, 1, 0, 24'h000160, 0, 0, 0, 0, 0);
    add(24'h000100, 1, 0, 0, 24'h000100, 0, 1, 0, 0, 1);
    add(24'h000200, 1, 0, 0, 24'h000200, 0, 2, 1, 0, 1);
    add(24'h000300, 1, 0, 0, 24'h000200, 0, 2, 1, 1, 1);
    add(24'h000301, 0, 0, 0, 24'h000200, 0, 2, 1, 0, 1);
    add(24'h000302, 1, 1, 0, 24'h000200, 0, 2, 1, 1, 1);
    add(24'h000303, 0, 0, 0, 24'h000200, 0, 2, 1, 0, 1);
    add(24'h000304, 0, 0, 0, 24'h000304, 0, 2, 1, 0, 0);
    add(24'h000305, 0, 1, 0, 24'h000100, 1, 2, 1, 0, 1);
    add(24'h000306, 1, 0, 0, 24'h000100, 1, 2, 1, 0, 1);
    add(24'h000307, 0, 0, 0, 24'h000100, 0, 2, 1, 0, 1);
    add(24'h000308, 0, 0, 0, 24'h000100, 0, 2, 1, 0, 1);
    add(24'h000309, 0, 1, 0, 24'h000200, 1, 2, 1, 0, 1);
    add(24'h000310, 0, 0, 0, 24'h000200, 1, 2, 1, 0, 1);
    add(24'h000311, 0, 0, 0, 24'h000200, 0, 2, 1, 0, 1);
    add(24'h000400, 0, 1, 0, 24'h000400, 0, 2, 1, 0, 0);
    add(24'h000401, 0, 0, 0, 24'h000401, 0, 2, 1, 0, 0);
    add(24'h000402, 1, 0, 0, 24'h000402, 0, 2, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), 30'h0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      bcd_time_in     = vecs[i].bcd;
      lap_pulse_in    = vecs[i].lap;
      recall_pulse_in = vecs[i].rec;
      clear_pulse_in  = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].e_data, vecs[i].e_dp, vecs[i].e_cnt, vecs[i].e_full,
           vecs[i].e_ovf, vecs[i].e_show});
      @(negedge clk);
    end

    // Asynchronous reset in the middle of lap browsing
    bcd_time_in = 24'h000500; lap_pulse_in = 1'b0; recall_pulse_in = 1'b1; clear_pulse_in = 1'b0;
    @(posedge clk); #1;
    chk("recall_enter", outs(), {24'h000100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    recall_pulse_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 30'h0);
    @(negedge clk);
    rst_n = 1'b1; bcd_time_in = 24'h000600;
    @(posedge clk); #1;
    chk("post_reset_live", outs(), {24'h000600, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    recall_pulse_in = 1'b1;
    @(posedge clk); #1;
    chk("recall_ignored", outs(), {24'h000600, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});

    // Recall entered directly from FREEZE, then stepped back to live
    @(negedge clk);
    recall_pulse_in = 1'b0; lap_pulse_in = 1'b1; bcd_time_in = 24'h000700;
    @(posedge clk); #1;
    chk("lap_after_reset", outs(), {24'h000700, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    lap_pulse_in = 1'b0; recall_pulse_in = 1'b1; bcd_time_in = 24'h000701;
    @(posedge clk); #1;
    chk("recall_from_freeze", outs(), {24'h000700, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    bcd_time_in = 24'h000702;
    @(posedge clk); #1;
    chk("recall_exit", outs(), {24'h000702, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    recall_pulse_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
